// File: rtl/warp_issue_scheduler_pkg.sv
// Shared types and defaults for the warp issue scheduler.
package warp_issue_scheduler_pkg;

  localparam int WARPS_PER_CORE        = 4;
  localparam int REG_ADDR_WIDTH        = 5;
  localparam int SCHED_BACKOFF_DEFAULT = 2;
  localparam int SCHED_BO_W            = 2;

  typedef enum logic {
    SCHED_FWD_OFF = 1'b0,
    SCHED_FWD_ON  = 1'b1
  } sched_fwd_mode_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_rr_find_next.sv
// Rotate-priority find-first: first set mask bit after start, wrapping back to start itself last.
module warp_issue_scheduler_rr_find_next #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;

  always_comb begin
    // rot[i] is warp (start+1+i) mod N, so rot[N-1] is start itself
    rot   = N'({mask, mask} >> (int'(start) + 1));
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = IW'((int'(start) + 1 + i) % N);
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue arbiter: probes one warp per cycle against the scoreboard, issues when clear,
// parks hazarded warps for a backoff window.
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
#(
  parameter int              NUM_WARPS      = WARPS_PER_CORE,
  parameter int              BACKOFF_CYCLES = SCHED_BACKOFF_DEFAULT,
  parameter sched_fwd_mode_e FWD_EN         = SCHED_FWD_ON,
  parameter int              CNT_WIDTH      = 32,
  parameter int              BO_W           = SCHED_BO_W,
  parameter int              RAW            = REG_ADDR_WIDTH,
  parameter int              WARP_ID_WIDTH  = id_width(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WARPS-1:0]         warp_active,
  input  logic [NUM_WARPS-1:0]         ibuf_valid,
  input  logic [NUM_WARPS*RAW-1:0]     ibuf_rs1,
  input  logic [NUM_WARPS*RAW-1:0]     ibuf_rs2,
  input  logic [NUM_WARPS*RAW-1:0]     ibuf_rs3,
  input  logic [NUM_WARPS*3-1:0]       ibuf_uses_rs,
  input  logic [NUM_WARPS*RAW-1:0]     ibuf_rd,
  input  logic [NUM_WARPS-1:0]         ibuf_reg_write,
  input  logic [NUM_WARPS-1:0]         ibuf_is_load,
  output logic [NUM_WARPS-1:0]         ibuf_pop,
  output logic                         sb_decode_valid,
  output logic [WARP_ID_WIDTH-1:0]     sb_warp_id,
  output logic [RAW-1:0]               sb_rs1,
  output logic [RAW-1:0]               sb_rs2,
  output logic [RAW-1:0]               sb_rs3,
  output logic                         sb_uses_rs1,
  output logic                         sb_uses_rs2,
  output logic                         sb_uses_rs3,
  input  logic                         sb_hazard_detected,
  input  logic                         sb_load_use_hazard,
  output logic                         sb_exec_issue,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [WARP_ID_WIDTH-1:0]     issue_warp_id,
  output logic [RAW-1:0]               issue_rd,
  output logic                         issue_reg_write,
  output logic                         issue_is_load,
  input  logic                         flush,
  input  logic [WARP_ID_WIDTH-1:0]     flush_warp_id,
  output logic [CNT_WIDTH-1:0]         hazard_stall_count
);

  logic [WARP_ID_WIDTH-1:0] cur;
  logic [BO_W-1:0]          backoff [NUM_WARPS];
  logic [CNT_WIDTH-1:0]     count;

  logic [NUM_WARPS-1:0]     elig;
  logic [NUM_WARPS-1:0]     cur_oh;
  logic [NUM_WARPS-1:0]     search_mask;
  logic                     elig_cur, block, fire, park, stalled, nxt_found;
  logic [WARP_ID_WIDTH-1:0] nxt_idx;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = rst_n && warp_active[w] && ibuf_valid[w] && (backoff[w] == '0) &&
                !(flush && (flush_warp_id == WARP_ID_WIDTH'(w)));
    end
  end

  assign cur_oh   = NUM_WARPS'(1) << cur;
  assign elig_cur = elig[cur];
  assign block    = (FWD_EN == SCHED_FWD_ON) ? sb_load_use_hazard : sb_hazard_detected;
  assign park     = elig_cur && block;
  assign fire     = issue_valid && issue_ready;
  assign stalled  = issue_valid && !issue_ready;
  // A warp parked this cycle must not be picked as its own successor
  assign search_mask = elig & ~(park ? cur_oh : '0);

  warp_issue_scheduler_rr_find_next #(
    .N  (NUM_WARPS),
    .IW (WARP_ID_WIDTH)
  ) u_find (
    .mask  (search_mask),
    .start (cur),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  assign sb_decode_valid = elig_cur;
  assign sb_warp_id      = cur;
  assign sb_rs1          = ibuf_rs1[cur*RAW +: RAW];
  assign sb_rs2          = ibuf_rs2[cur*RAW +: RAW];
  assign sb_rs3          = ibuf_rs3[cur*RAW +: RAW];
  assign sb_uses_rs1     = ibuf_uses_rs[cur*3];
  assign sb_uses_rs2     = ibuf_uses_rs[cur*3 + 1];
  assign sb_uses_rs3     = ibuf_uses_rs[cur*3 + 2];

  assign issue_valid     = elig_cur && !block;
  assign issue_warp_id   = cur;
  assign issue_rd        = ibuf_rd[cur*RAW +: RAW];
  assign issue_reg_write = ibuf_reg_write[cur];
  assign issue_is_load   = ibuf_is_load[cur];
  assign ibuf_pop        = fire ? cur_oh : '0;
  assign sb_exec_issue   = fire;

  assign hazard_stall_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= '0;
      count <= '0;
      for (int w = 0; w < NUM_WARPS; w++) backoff[w] <= '0;
    end else begin
      // An offered-but-unaccepted instruction pins the pointer
      if (!stalled && nxt_found) cur <= nxt_idx;
      if (park && (count != '1)) count <= count + 1'b1;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush && (flush_warp_id == WARP_ID_WIDTH'(w)))
          backoff[w] <= '0;
        else if (park && (cur == WARP_ID_WIDTH'(w)))
          backoff[w] <= BO_W'(BACKOFF_CYCLES);
        else if (backoff[w] != '0)
          backoff[w] <= backoff[w] - 1'b1;
      end
    end
  end

endmodule
